// File: rtl/entrada_pin_if.sv
// Keypad-side and controller-side signals of the PIN entry stage.
// The master drives key strobes; the slave (entrada_pin) drives the code outputs.
interface entrada_pin_if;
    logic       Tecla_valida;
    logic [3:0] Tecla;
    logic [7:0] Pin;
    logic       Pin_listo;
    logic       Error;
    logic [1:0] Digitos;

    modport master (
        output Tecla_valida, Tecla,
        input  Pin, Pin_listo, Error, Digitos
    );

    modport slave (
        input  Tecla_valida, Tecla,
        output Pin, Pin_listo, Error, Digitos
    );
endinterface

// File: rtl/entrada_pin.sv
// Two-digit BCD PIN entry: collects keypad digits, handles clear/enter/timeout,
// and presents a completed non-zero code on Pin for exactly one cycle.
module entrada_pin #(
    parameter int TIMEOUT = 100,
    parameter int TW      = 7
) (
    input  logic         Clk,
    input  logic         Reset,
    entrada_pin_if.slave bus
);
    typedef enum logic [1:0] {
        ESPERA      = 2'd0,
        UN_DIGITO   = 2'd1,
        DOS_DIGITOS = 2'd2
    } estado_t;

    localparam logic [3:0]    KEY_BORRAR = 4'hA;
    localparam logic [3:0]    KEY_ENTER  = 4'hB;
    // Expiry is taken on the edge that completes TIMEOUT idle cycles.
    localparam logic [TW-1:0] CNT_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_MAX    = {TW{1'b1}};

    estado_t       state_q, state_d;
    logic [3:0]    d1_q, d1_d;
    logic [3:0]    d0_q, d0_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [7:0]    pin_q, pin_d;
    logic          listo_q, listo_d;
    logic          error_q, error_d;

    logic es_digito;
    assign es_digito = (bus.Tecla <= 4'h9);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ESPERA;
            d1_q    <= 4'h0;
            d0_q    <= 4'h0;
            cnt_q   <= '0;
            pin_q   <= 8'h00;
            listo_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            cnt_q   <= cnt_d;
            pin_q   <= pin_d;
            listo_q <= listo_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        cnt_d   = cnt_q;
        pin_d   = 8'h00;
        listo_d = 1'b0;
        error_d = 1'b0;

        if (bus.Tecla_valida) begin
            // Any strobe, even an ignored code, counts as activity.
            cnt_d = '0;
            case (state_q)
                ESPERA: begin
                    if (es_digito) begin
                        d1_d    = bus.Tecla;
                        state_d = UN_DIGITO;
                    end else if (bus.Tecla == KEY_ENTER) begin
                        error_d = 1'b1;
                    end
                end
                UN_DIGITO: begin
                    if (es_digito) begin
                        d0_d    = bus.Tecla;
                        state_d = DOS_DIGITOS;
                    end else if (bus.Tecla == KEY_ENTER) begin
                        error_d = 1'b1;
                        state_d = ESPERA;
                    end else if (bus.Tecla == KEY_BORRAR) begin
                        state_d = ESPERA;
                    end
                end
                DOS_DIGITOS: begin
                    if (es_digito) begin
                        error_d = 1'b1;
                    end else if (bus.Tecla == KEY_BORRAR) begin
                        state_d = ESPERA;
                    end else if (bus.Tecla == KEY_ENTER) begin
                        state_d = ESPERA;
                        // "00" would look like idle downstream, so reject it.
                        if ({d1_q, d0_q} != 8'h00) begin
                            pin_d   = {d1_q, d0_q};
                            listo_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                default: state_d = ESPERA;
            endcase
        end else if (state_q == ESPERA) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = ESPERA;
            cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        case (state_q)
            UN_DIGITO:   bus.Digitos = 2'd1;
            DOS_DIGITOS: bus.Digitos = 2'd2;
            default:     bus.Digitos = 2'd0;
        endcase
    end

    assign bus.Pin       = pin_q;
    assign bus.Pin_listo = listo_q;
    assign bus.Error     = error_q;
endmodule

// File: tb/tb_entrada_pin.sv
// Directed bench for entrada_pin: digit-queue reference model checked every cycle,
// plus literal expectations taken from the key sequences it drives.
module tb_entrada_pin;
    localparam int TIMEOUT = 10;
    localparam int TW      = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    entrada_pin_if bus ();

    entrada_pin #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the held digits as a queue, plus an idle-cycle count.
    int         digs[$];
    int         idle      = 0;
    logic [7:0] exp_pin   = 8'h00;
    logic       exp_listo = 1'b0;
    logic       exp_err   = 1'b0;
    bit         chk_en    = 1'b0;

    initial begin
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) begin
                digs.delete();
                idle      = 0;
                exp_pin   = 8'h00;
                exp_listo = 1'b0;
                exp_err   = 1'b0;
            end else begin
                exp_pin   = 8'h00;
                exp_listo = 1'b0;
                exp_err   = 1'b0;
                if (bus.Tecla_valida) begin
                    idle = 0;
                    if (bus.Tecla <= 4'd9) begin
                        if (digs.size() < 2) digs.push_back(int'(bus.Tecla));
                        else exp_err = 1'b1;
                    end else if (bus.Tecla == 4'hA) begin
                        digs.delete();
                    end else if (bus.Tecla == 4'hB) begin
                        if (digs.size() == 2 && (digs[0] * 10 + digs[1]) != 0) begin
                            exp_pin   = 8'(digs[0] * 16 + digs[1]);
                            exp_listo = 1'b1;
                        end else begin
                            exp_err = 1'b1;
                        end
                        digs.delete();
                    end
                end else if (digs.size() == 0) begin
                    idle = 0;
                end else begin
                    idle++;
                    if (idle >= TIMEOUT) begin
                        digs.delete();
                        idle = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                chk("model_pin",     bus.Pin,             exp_pin);
                chk("model_listo",   8'(bus.Pin_listo),   8'(exp_listo));
                chk("model_error",   8'(bus.Error),       8'(exp_err));
                chk("model_digitos", 8'(bus.Digitos),     8'(digs.size()));
            end
        end
    end

    task automatic key(input logic [3:0] k);
        bus.Tecla_valida = 1'b1;
        bus.Tecla        = k;
        @(posedge Clk);
        #1;
        bus.Tecla_valida = 1'b0;
        $display("key %h -> Pin=%h listo=%b err=%b dig=%0d", k, bus.Pin, bus.Pin_listo, bus.Error, bus.Digitos);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Tecla_valida = 1'b0;
        bus.Tecla        = 4'h0;
        #12;
        chk("reset_pin",     bus.Pin,             8'h00);
        chk("reset_listo",   8'(bus.Pin_listo),   8'h00);
        chk("reset_error",   8'(bus.Error),       8'h00);
        chk("reset_digitos", 8'(bus.Digitos),     8'h00);
        @(posedge Clk);
        #1;
        Reset  = 1'b0;
        chk_en = 1'b1;
        idle_cycles(2);

        // 0, 8, enter -> 08 for exactly one cycle
        key(4'h0); key(4'h8); key(4'hB);
        chk("send08_pin",   bus.Pin,           8'h08);
        chk("send08_listo", 8'(bus.Pin_listo), 8'h01);
        idle_cycles(1);
        chk("send08_after_pin", bus.Pin,         8'h00);
        chk("send08_after_dig", 8'(bus.Digitos), 8'h00);

        // Single digit then enter -> rejected
        key(4'h3); key(4'hB);
        chk("one_digit_err", 8'(bus.Error), 8'h01);
        chk("one_digit_pin", bus.Pin,       8'h00);
        chk("one_digit_dig", 8'(bus.Digitos), 8'h00);

        // 00 is rejected
        key(4'h0); key(4'h0); key(4'hB);
        chk("zero_err",   8'(bus.Error),     8'h01);
        chk("zero_listo", 8'(bus.Pin_listo), 8'h00);

        // Enter with nothing held
        key(4'hB);
        chk("empty_enter_err", 8'(bus.Error), 8'h01);

        // Third digit rejected, then 12 sent
        key(4'h1); key(4'h2); key(4'h5);
        chk("third_err", 8'(bus.Error),   8'h01);
        chk("third_dig", 8'(bus.Digitos), 8'h02);
        key(4'hB);
        chk("send12_pin", bus.Pin, 8'h12);

        // Timeout after TIMEOUT idle cycles
        key(4'h7);
        idle_cycles(TIMEOUT - 1);
        chk("pre_timeout_dig", 8'(bus.Digitos), 8'h01);
        idle_cycles(1);
        chk("timeout_dig", 8'(bus.Digitos), 8'h00);
        chk("timeout_err", 8'(bus.Error),   8'h00);

        // Key on the expiry edge wins
        key(4'h7);
        idle_cycles(TIMEOUT - 1);
        key(4'h9);
        chk("expiry_key_dig", 8'(bus.Digitos), 8'h02);
        key(4'hB);
        chk("send79_pin", bus.Pin, 8'h79);

        // Ignored code restarts the inactivity count
        key(4'h6);
        idle_cycles(TIMEOUT - 2);
        key(4'hE);
        idle_cycles(TIMEOUT - 2);
        chk("ignored_keeps_dig", 8'(bus.Digitos), 8'h01);
        key(4'hA);
        chk("borrar_one_dig", 8'(bus.Digitos), 8'h00);

        // 4, 5, borrar, 0, 8, enter -> 08 once
        key(4'h4); key(4'h5); key(4'hA);
        chk("borrar_dig", 8'(bus.Digitos), 8'h00);
        key(4'h0); key(4'h8); key(4'hB);
        chk("send08b_pin", bus.Pin, 8'h08);
        idle_cycles(1);
        chk("send08b_once", bus.Pin, 8'h00);

        // Asynchronous reset mid-entry
        key(4'h4); key(4'h5);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_dig", 8'(bus.Digitos), 8'h00);
        #3;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        key(4'hB);
        chk("post_rst_pin", bus.Pin,       8'h00);
        chk("post_rst_err", 8'(bus.Error), 8'h01);
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
